// File: rtl/conv1d_pkg.sv
// Shared constants for the 1D convolution engine and its result streamer.
// Holds feature-map geometry, streamer state encodings and saturation bounds.
package conv1d_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ACCUM_WIDTH = 24;
    localparam int INPUT_LEN   = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int OUTPUT_LEN  = INPUT_LEN - KERNEL_SIZE + 1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_READ = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_FIN  = 3'd4;

    localparam int SAT_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_WIDTH - 1));

    function automatic int sat_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(2 ** (w - 1));
    endfunction

endpackage

// File: rtl/conv1d_requant.sv
// Combinational requantizer: arithmetic shift, optional ReLU, signed saturation.
// ReLU is enabled by defining CONV1D_STREAM_RELU_EN.
module conv1d_requant #(
    parameter int ACCUM_WIDTH = conv1d_pkg::ACCUM_WIDTH,
    parameter int DATA_WIDTH  = conv1d_pkg::DATA_WIDTH,
    parameter int SHIFT       = 0
) (
    input  logic signed [ACCUM_WIDTH-1:0] data_i,
    output logic signed [DATA_WIDTH-1:0]  data_o
);
    import conv1d_pkg::*;

    localparam logic signed [ACCUM_WIDTH-1:0] MAXV = ACCUM_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACCUM_WIDTH-1:0] MINV = ACCUM_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACCUM_WIDTH-1:0] shifted;

    always_comb begin
        shifted = data_i >>> SHIFT;
`ifdef CONV1D_STREAM_RELU_EN
        if (shifted < 0) shifted = '0;
`endif
        if (shifted > MAXV)
            data_o = MAXV[DATA_WIDTH-1:0];
        else if (shifted < MINV)
            data_o = MINV[DATA_WIDTH-1:0];
        else
            data_o = shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/conv1d_result_streamer.sv
// Reads the conv engine's accumulator map, requantizes each word and streams it
// out on valid/ready with a last marker. Optional ReLU: CONV1D_STREAM_RELU_EN.
module conv1d_result_streamer #(
    parameter int ACCUM_WIDTH = conv1d_pkg::ACCUM_WIDTH,
    parameter int DATA_WIDTH  = conv1d_pkg::DATA_WIDTH,
    parameter int OUTPUT_LEN  = conv1d_pkg::OUTPUT_LEN,
    parameter int ADDR_WIDTH  = 3,
    parameter int SHIFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic signed [ACCUM_WIDTH-1:0] rd_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic signed [DATA_WIDTH-1:0]  m_data,
    output logic                          m_last
);
    import conv1d_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUTPUT_LEN - 1);

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_last_q, m_last_d;
    logic signed [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic signed [DATA_WIDTH-1:0] req_data;

    conv1d_requant #(
        .ACCUM_WIDTH(ACCUM_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant (
        .data_i(rd_data),
        .data_o(req_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            // Read data lands this cycle; capture it already requantized.
            ST_WAIT: begin
                m_data_d  = req_data;
                m_valid_d = 1'b1;
                m_last_d  = (idx_q == LAST_IDX);
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state_q == ST_READ);
        rd_addr = idx_q;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_FIN);
        m_valid = m_valid_q;
        m_last  = m_last_q;
        m_data  = m_data_q;
    end

endmodule
